// File: rtl/time_unit_counter_pkg.sv
// Shared divisor defaults and speed_sel encoding for the clock datapath counters.
package time_unit_counter_pkg;

  localparam int DIV_REAL_DEF = 50_000_000;
  localparam int DIV_D1_DEF   = 833_334;
  localparam int DIV_D2_DEF   = 13_889;
  localparam int DIV_D3_DEF   = 579;
  localparam int DIV_D4_DEF   = 20;
  localparam int DIV_D5_DEF   = 2;

  localparam logic [2:0] SPD_REAL = 3'd0;
  localparam logic [2:0] SPD_D1   = 3'd1;
  localparam logic [2:0] SPD_D2   = 3'd2;
  localparam logic [2:0] SPD_D3   = 3'd3;
  localparam logic [2:0] SPD_D4   = 3'd4;
  localparam logic [2:0] SPD_D5   = 3'd5;
  localparam int         SPD_COUNT = 8;

endpackage

// File: rtl/time_unit_counter_tick_prescaler.sv
// Free-running divider producing one tick every DIV_sel cycles; hold parks it at 0.
module tick_prescaler
  import time_unit_counter_pkg::*;
#(
  parameter int PRE_W    = 26,
  parameter int DIV_REAL = DIV_REAL_DEF,
  parameter int DIV_D1   = DIV_D1_DEF,
  parameter int DIV_D2   = DIV_D2_DEF,
  parameter int DIV_D3   = DIV_D3_DEF,
  parameter int DIV_D4   = DIV_D4_DEF,
  parameter int DIV_D5   = DIV_D5_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] speed_sel,
  input  logic       hold,
  output logic       tick
);

  // Indexed by the SPD_* encoding; codes 6 and 7 fall back to real time.
  localparam int DIVS [SPD_COUNT] = '{DIV_REAL, DIV_D1, DIV_D2, DIV_D3,
                                      DIV_D4, DIV_D5, DIV_REAL, DIV_REAL};

  logic [PRE_W-1:0] div_table [SPD_COUNT];
  logic [PRE_W-1:0] div_last;
  logic [PRE_W-1:0] pcnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SPD_COUNT; gi++) begin : g_div
      assign div_table[gi] = PRE_W'(DIVS[gi] - 1);
    end
  endgenerate

  assign div_last = div_table[speed_sel];

  // >= rather than == so a switch to a shorter divisor ticks at once instead of running away.
  assign tick = !hold && (pcnt_reg >= div_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pcnt_reg <= '0;
    else if (hold || pcnt_reg >= div_last)
      pcnt_reg <= '0;
    else
      pcnt_reg <= pcnt_reg + PRE_W'(1);
  end

endmodule

// File: rtl/time_unit_counter.sv
// Editable wrap-around time unit (sec/min/hour/day/month/year) with run-mode carry output.
module time_unit_counter
  import time_unit_counter_pkg::*;
#(
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 59,
  parameter int WIDTH    = 7,
  parameter int CHAIN    = 0,
  parameter int PRE_W    = 26,
  parameter int DIV_REAL = DIV_REAL_DEF,
  parameter int DIV_D1   = DIV_D1_DEF,
  parameter int DIV_D2   = DIV_D2_DEF,
  parameter int DIV_D3   = DIV_D3_DEF,
  parameter int DIV_D4   = DIV_D4_DEF,
  parameter int DIV_D5   = DIV_D5_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       speed_sel,
  input  logic             tick_in,
  input  logic             edit_en,
  input  logic             edit_sel,
  input  logic             edit_digit,
  input  logic             key_plus,
  input  logic             key_minus,
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] value_reg, value_next;
  logic             carry_reg, carry_next;
  logic [1:0]       key_reg, key_prev_reg;   // bit 0 = plus, bit 1 = minus
  logic [1:0]       key_fall;
  logic             step;
  logic             edit_go;

  generate
    if (CHAIN == 0) begin : g_pre
      logic pre_tick;
      logic unused_tick_in;
      assign unused_tick_in = tick_in;
      tick_prescaler #(
        .PRE_W(PRE_W), .DIV_REAL(DIV_REAL), .DIV_D1(DIV_D1), .DIV_D2(DIV_D2),
        .DIV_D3(DIV_D3), .DIV_D4(DIV_D4), .DIV_D5(DIV_D5)
      ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .speed_sel (speed_sel),
        .hold      (edit_en),
        .tick      (pre_tick)
      );
      assign step = pre_tick && !edit_en;
    end else begin : g_chain
      logic unused_speed_sel;
      assign unused_speed_sel = ^speed_sel;
      assign step = tick_in && !edit_en;
    end
  endgenerate

  // Digit-wise edit with wrap confined to [MIN_VAL, MAX_VAL].
  function automatic logic [WIDTH-1:0] edit_value(input logic [WIDTH-1:0] cur,
                                                  input logic tens, input logic plus);
    int v, t, o, r, top;
    v = int'(cur);
    t = v / 10;
    o = v % 10;
    r = v;
    if (!tens && plus)
      r = (o == 9 || v == MAX_VAL) ? ((10 * t > MIN_VAL) ? 10 * t : MIN_VAL) : v + 1;
    else if (!tens)
      r = (o == 0 || v == MIN_VAL) ? ((10 * t + 9 < MAX_VAL) ? 10 * t + 9 : MAX_VAL) : v - 1;
    else if (plus)
      r = (v + 10 > MAX_VAL) ? ((o > MIN_VAL) ? o : MIN_VAL) : v + 10;
    else begin
      top = 10 * (MAX_VAL / 10) + o;
      if (top > MAX_VAL)
        top = top - 10;
      r = (v - 10 < MIN_VAL) ? top : v - 10;
    end
    return WIDTH'(r);
  endfunction

  assign key_fall = key_prev_reg & ~key_reg;
  // Simultaneous presses cancel out.
  assign edit_go  = edit_en && edit_sel && (key_fall[0] ^ key_fall[1]);

  always_comb begin
    value_next = value_reg;
    carry_next = 1'b0;
    if (edit_en) begin
      if (edit_go)
        value_next = edit_value(value_reg, edit_digit, key_fall[0]);
    end else if (step) begin
      if (value_reg == MAX_W) begin
        value_next = MIN_W;
        carry_next = 1'b1;
      end else begin
        value_next = value_reg + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_reg    <= MIN_W;
      carry_reg    <= 1'b0;
      key_reg      <= 2'b11;
      key_prev_reg <= 2'b11;
    end else begin
      value_reg    <= value_next;
      carry_reg    <= carry_next;
      key_reg      <= {key_minus, key_plus};
      key_prev_reg <= key_reg;
    end
  end

  assign value     = value_reg;
  assign carry_out = carry_reg;

endmodule

// File: tb/tb_time_unit_counter.sv
// Scoreboard bench: seconds (0..59, self-timed), day (1..31, chained), hour (0..23, chained).
module tb_time_unit_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] speed_sel;
  logic       tick_day, tick_hr;
  logic       edit_en, edit_digit, key_plus, key_minus;
  logic       sel_sec, sel_day, sel_hr;
  logic [6:0] sec_val;
  logic [4:0] day_val, hr_val;
  logic       sec_carry, day_carry, hr_carry;

  int n_checks = 0;
  int n_fail   = 0;
  int day_m    = 1;
  int hr_m     = 0;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  time_unit_counter #(.MIN_VAL(0), .MAX_VAL(59), .WIDTH(7), .CHAIN(0)) u_sec (
    .clk(clk), .reset(reset), .speed_sel(speed_sel), .tick_in(1'b0),
    .edit_en(edit_en), .edit_sel(sel_sec), .edit_digit(edit_digit),
    .key_plus(key_plus), .key_minus(key_minus), .value(sec_val), .carry_out(sec_carry));

  time_unit_counter #(.MIN_VAL(1), .MAX_VAL(31), .WIDTH(5), .CHAIN(1)) u_day (
    .clk(clk), .reset(reset), .speed_sel(speed_sel), .tick_in(tick_day),
    .edit_en(edit_en), .edit_sel(sel_day), .edit_digit(edit_digit),
    .key_plus(key_plus), .key_minus(key_minus), .value(day_val), .carry_out(day_carry));

  time_unit_counter #(.MIN_VAL(0), .MAX_VAL(23), .WIDTH(5), .CHAIN(1)) u_hr (
    .clk(clk), .reset(reset), .speed_sel(speed_sel), .tick_in(tick_hr),
    .edit_en(edit_en), .edit_sel(sel_hr), .edit_digit(edit_digit),
    .key_plus(key_plus), .key_minus(key_minus), .value(hr_val), .carry_out(hr_carry));

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, act, e.exp);
    end
  endtask

  function automatic int cur_val(input int which);
    case (which)
      0:       return int'(sec_val);
      1:       return int'(day_val);
      default: return int'(hr_val);
    endcase
  endfunction

  // Chained run: tick_in high for n consecutive cycles, carries counted on the way.
  task automatic run_ticks(input int which, input int n, input string tag);
    int m, lo, hi, carries, exp_carries;
    m = (which == 1) ? day_m : hr_m;
    lo = (which == 1) ? 1 : 0;
    hi = (which == 1) ? 31 : 23;
    carries = 0;
    exp_carries = 0;
    @(negedge clk);
    if (which == 1) tick_day = 1'b1; else tick_hr = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (m == hi) begin
        m = lo;
        exp_carries++;
      end else begin
        m++;
      end
      @(negedge clk);
      carries += (which == 1) ? int'(day_carry) : int'(hr_carry);
    end
    tick_day = 1'b0;
    tick_hr  = 1'b0;
    if (which == 1) day_m = m; else hr_m = m;
    sb_push({tag, "_val"}, m);
    sb_push({tag, "_carries"}, exp_carries);
    sb_pop(cur_val(which));
    sb_pop(carries);
  endtask

  // target: which unit gets edit_sel (-1 none); obs: which unit is compared.
  task automatic do_edit(input int target, input int obs, input logic digit,
                         input logic plus, input logic minus, input int hold,
                         input int exp, input string tag);
    @(negedge clk);
    sel_day    = (target == 1);
    sel_hr     = (target == 2);
    edit_digit = digit;
    sb_push(tag, exp);
    key_plus  = ~plus;
    key_minus = ~minus;
    repeat (hold) @(negedge clk);
    key_plus  = 1'b1;
    key_minus = 1'b1;
    repeat (3) @(negedge clk);
    sb_pop(cur_val(obs));
    if (obs == 1) day_m = exp;
    if (obs == 2) hr_m = exp;
  endtask

  initial begin
    reset = 1'b0; speed_sel = 3'd5; tick_day = 1'b0; tick_hr = 1'b0;
    edit_en = 1'b0; edit_digit = 1'b0; key_plus = 1'b1; key_minus = 1'b1;
    sel_sec = 1'b0; sel_day = 1'b0; sel_hr = 1'b0;

    repeat (3) @(negedge clk);
    sb_push("rst_sec_val", 0);   sb_pop(int'(sec_val));
    sb_push("rst_sec_carry", 0); sb_pop(int'(sec_carry));
    sb_push("rst_day_val", 1);   sb_pop(int'(day_val));
    sb_push("rst_hr_val", 0);    sb_pop(int'(hr_val));
    reset = 1'b1;

    // Seconds at DIV 2: +1 every 2 cycles, single-cycle carry on 59 -> 0.
    for (int n = 1; n <= 130; n++) begin
      sb_push("sec_val", (n / 2) % 60);
      sb_push("sec_carry", (n % 2 == 0 && (n / 2) % 60 == 0) ? 1 : 0);
      @(negedge clk);
      sb_pop(int'(sec_val));
      sb_pop(int'(sec_carry));
    end

    run_ticks(1, 31, "day_chain");
    run_ticks(2, 23, "hr_chain");

    edit_en = 1'b1;
    do_edit(2, 2, 1'b0, 1'b1, 1'b0, 4, 20, "hr_ones_plus_23");
    do_edit(2, 2, 1'b0, 1'b0, 1'b1, 4, 23, "hr_ones_minus_20");
    do_edit(1, 1, 1'b0, 1'b0, 1'b1, 4, 9,  "day_ones_minus_1");

    @(negedge clk) edit_en = 1'b0;
    run_ticks(2, 8, "hr_to_7");
    @(negedge clk) edit_en = 1'b1;
    do_edit(2, 2, 1'b1, 1'b0, 1'b1, 4, 17, "hr_tens_minus_7");
    do_edit(2, 2, 1'b1, 1'b1, 1'b0, 4, 7,  "hr_tens_plus_17");

    @(negedge clk) edit_en = 1'b0;
    run_ticks(2, 12, "hr_to_19");
    @(negedge clk) edit_en = 1'b1;
    do_edit(2, 2, 1'b1, 1'b1, 1'b0, 4, 9, "hr_tens_plus_19");

    @(negedge clk) edit_en = 1'b0;
    run_ticks(2, 20, "hr_to_5");
    @(negedge clk) edit_en = 1'b1;
    do_edit(2, 2, 1'b1, 1'b0, 1'b1, 4, 15, "hr_tens_minus_5");

    do_edit(2, 2, 1'b0, 1'b1, 1'b0, 100, 16, "hr_hold_plus");
    do_edit(2, 2, 1'b0, 1'b1, 1'b1, 4, hr_m, "hr_both_keys");
    do_edit(-1, 1, 1'b0, 1'b1, 1'b0, 4, day_m, "day_unselected");
    do_edit(-1, 2, 1'b0, 1'b0, 1'b1, 4, hr_m, "hr_unselected");

    // Asynchronous reset in the middle of a key press, checked before any clock edge.
    @(negedge clk);
    sel_hr = 1'b1;
    key_plus = 1'b0;
    #2 reset = 1'b0;
    #1;
    sb_push("midrst_hr_val", 0);     sb_pop(int'(hr_val));
    sb_push("midrst_day_val", 1);    sb_pop(int'(day_val));
    sb_push("midrst_sec_carry", 0);  sb_pop(int'(sec_carry));
    @(negedge clk);
    key_plus = 1'b1; edit_en = 1'b0; sel_hr = 1'b0; speed_sel = 3'd3;
    @(negedge clk) reset = 1'b1;

    // DIV 579 for 500 cycles, then switch to DIV 2.
    repeat (500) @(negedge clk);
    sb_push("spd3_sec_val", 0); sb_pop(int'(sec_val));
    speed_sel = 3'd5;
    for (int k = 1; k <= 5; k++) begin
      sb_push("spd5_sec_val", (k + 1) / 2);
      @(negedge clk);
      sb_pop(int'(sec_val));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
